// File: rtl/double_addsub_mat_lanes.sv
// Element-wise IEEE-754 double matrix add/subtract, processed LANES elements per cycle
// through LATENCY-deep adder pipelines with a registered result matrix and sticky flags.
module double_addsub_mat_lanes #(
    parameter int SIZE_A  = 8,
    parameter int SIZE_B  = 8,
    parameter int LANES   = 4,
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [63:0] mat_a   [SIZE_A][SIZE_B],
    input  logic [63:0] mat_b   [SIZE_A][SIZE_B],
    output logic [63:0] mat_out [SIZE_A][SIZE_B],
    output logic        busy,
    output logic        done,
    output logic [3:0]  flags
);

    localparam int NE = SIZE_A * SIZE_B;
    localparam int NB = NE / LANES;
    localparam int BW = $clog2(NB + 1);
    localparam int DW = $clog2(LATENCY + 1);

    if ((SIZE_B % LANES) != 0) begin : g_bad_lanes
        $error("SIZE_B must be a multiple of LANES");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

    // Returns {nan, overflow, underflow, zero, result}; round-to-nearest-even.
    function automatic logic [67:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, swap, sx, sy, eff_sub;
        logic        found, g, r, st, up;
        logic [63:0] x, y, res;
        logic [10:0] ex, ey;
        logic [52:0] mx, my;
        logic [11:0] d, e, sh;
        logic [55:0] xe, ye, ys, lost;
        logic [56:0] s;
        logic [53:0] m;
        logic [5:0]  lz;
        logic [3:0]  fl;
        a_nan = (&a[62:52]) && (|a[51:0]);
        b_nan = (&b[62:52]) && (|b[51:0]);
        a_inf = (&a[62:52]) && !(|a[51:0]);
        b_inf = (&b[62:52]) && !(|b[51:0]);
        res   = '0;
        fl    = '0;
        swap  = 1'b0;
        x = a; y = b; sx = 1'b0; sy = 1'b0; ex = '0; ey = '0; mx = '0; my = '0;
        d = '0; e = '0; sh = '0; xe = '0; ye = '0; ys = '0; lost = '0; s = '0; m = '0;
        lz = '0; found = 1'b0; g = 1'b0; r = 1'b0; st = 1'b0; up = 1'b0; eff_sub = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[63] ^ b[63]))) begin
            res = 64'h7FF8_0000_0000_0000;
            fl  = 4'b1000;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else begin
            swap = b[62:0] > a[62:0];
            x    = swap ? b : a;
            y    = swap ? a : b;
            sx   = x[63];
            sy   = y[63];
            mx   = {|x[62:52], x[51:0]};
            my   = {|y[62:52], y[51:0]};
            ex   = (x[62:52] == 11'd0) ? 11'd1 : x[62:52];
            ey   = (y[62:52] == 11'd0) ? 11'd1 : y[62:52];
            d    = {1'b0, ex} - {1'b0, ey};
            xe   = {mx, 3'b000};
            ye   = {my, 3'b000};
            if (d >= 12'd56) begin
                ys = {55'd0, |ye};
            end else begin
                ys    = ye >> d;
                lost  = ye << (6'd56 - d[5:0]);
                ys[0] = ys[0] | (|lost);
            end
            eff_sub = sx ^ sy;
            s = eff_sub ? ({1'b0, xe} - {1'b0, ys}) : ({1'b0, xe} + {1'b0, ys});
            e = {1'b0, ex};
            if (s[56]) begin
                s = {1'b0, s[56:2], s[1] | s[0]};
                e = e + 12'd1;
            end else begin
                lz = 6'd56;
                for (int i = 55; i >= 0; i--) begin
                    if (!found && s[i]) begin
                        lz    = 6'(55 - i);
                        found = 1'b1;
                    end
                end
                // Stop normalising at the minimum exponent so tiny results become subnormal.
                sh = ({6'd0, lz} > (e - 12'd1)) ? (e - 12'd1) : {6'd0, lz};
                s  = s << sh;
                e  = e - sh;
            end
            g  = s[2];
            r  = s[1];
            st = s[0];
            up = g && (r || st || s[3]);
            m  = {1'b0, s[55:3]} + {53'd0, up};
            if (m[53]) begin
                m = m >> 1;
                e = e + 12'd1;
            end
            if (!m[52]) begin
                e = 12'd0;
            end
            if (e >= 12'd2047) begin
                res = {sx, 11'h7FF, 52'd0};
                fl  = 4'b0100;
            end else if (m == 54'd0) begin
                res = {sx & sy, 63'd0};
                fl  = 4'b0001;
            end else begin
                res   = {sx, e[10:0], m[51:0]};
                fl[1] = (e == 12'd0);
            end
        end
        return {fl, res};
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            sub_q;
    logic            done_q, done_d;
    logic [3:0]      flags_q;
    logic            accept;
    logic            unit_en;
    logic            wb;
    logic [3:0]      wb_flags;

    logic [63:0]     a_flat  [NE];
    logic [63:0]     b_flat  [NE];
    logic [63:0]     out_q   [NE];
    logic [63:0]     opa     [LANES];
    logic [63:0]     opb     [LANES];
    logic [67:0]     unit_out[LANES];

    logic            vld_q [LATENCY];
    logic [BW-1:0]   idx_q [LATENCY];
    logic [63:0]     res_q [LATENCY][LANES];
    logic [3:0]      fl_q  [LATENCY][LANES];

    for (genvar r = 0; r < SIZE_A; r++) begin : g_row
        for (genvar c = 0; c < SIZE_B; c++) begin : g_col
            assign a_flat[r*SIZE_B+c] = mat_a[r][c];
            assign b_flat[r*SIZE_B+c] = mat_b[r][c];
            assign mat_out[r][c]      = out_q[r*SIZE_B+c];
        end
    end

    assign unit_en = (state_q != StIdle);
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign flags   = flags_q;
    assign wb      = unit_en && vld_q[LATENCY-1];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    beat_d  = '0;
                    drain_d = '0;
                    accept  = 1'b1;
                end
            end
            StIssue: begin
                if (beat_q == BW'(NB - 1)) begin
                    state_d = StDrain;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StDrain: begin
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        done_d = (state_q == StDrain) && (drain_q == DW'(LATENCY - 1));
    end

    // Lane operand select; subtraction flips the sign of B.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            opa[l] = '0;
            opb[l] = '0;
        end
        for (int k = 0; k < NB; k++) begin
            if (beat_q == BW'(k)) begin
                for (int l = 0; l < LANES; l++) begin
                    opa[l] = a_flat[k*LANES+l];
                    opb[l] = b_flat[k*LANES+l] ^ {sub_q, 63'd0};
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            unit_out[l] = fp_add(opa[l], opb[l]);
        end
    end

    always_comb begin
        wb_flags = '0;
        for (int l = 0; l < LANES; l++) begin
            wb_flags = wb_flags | fl_q[LATENCY-1][l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            drain_q <= '0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            if (accept) begin
                sub_q <= op_sub;
            end
            if (accept) begin
                flags_q <= '0;
            end else if (wb) begin
                flags_q <= flags_q | wb_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                idx_q[i] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    res_q[i][l] <= '0;
                    fl_q[i][l]  <= '0;
                end
            end
        end else if (unit_en) begin
            vld_q[0] <= (state_q == StIssue);
            idx_q[0] <= beat_q;
            for (int l = 0; l < LANES; l++) begin
                res_q[0][l] <= unit_out[l][63:0];
                fl_q[0][l]  <= unit_out[l][67:64];
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
                for (int l = 0; l < LANES; l++) begin
                    res_q[i][l] <= res_q[i-1][l];
                    fl_q[i][l]  <= fl_q[i-1][l];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NE; n++) begin
                out_q[n] <= '0;
            end
        end else if (wb) begin
            for (int n = 0; n < NE; n++) begin
                if (idx_q[LATENCY-1] == BW'(n / LANES)) begin
                    out_q[n] <= res_q[LATENCY-1][n % LANES];
                end
            end
        end
    end

endmodule
